branch_resolver: RTL

- EX-stage counterpart of the branch predictor: evaluates B-type conditions and jalr targets, compares them with the prediction carried down the pipeline, and drives the predictor's training and rollback inputs.
- Outputs: corrected_result/B_type for training, the registered *_branch_failed set, PL_flush, and redirect_pc.
- Sits between the ID/EX register and the fetch PC mux.

---
 rtl/branch_resolver_pkg.sv | 34 +++
 rtl/branch_resolver_branch_cond_unit.sv | 42 ++++
 rtl/branch_resolver.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolver_pkg.sv
// branch_resolver_pkg
// Shared definitions for the EX-stage branch resolver:
//   - one-hot branch-type encodings (bit order beq, bne, blt, bge, bltu, bgeu)
//   - the `zero` constant used when clearing single-bit state
//   - resolver FSM state encoding (RUN / FLUSH)
//   - saturating increment helper for the optional performance counters
`timescale 1ns/1ps

package branch_resolver_pkg;

  localparam int unsigned BR_TYPE_W = 6;

  localparam logic [BR_TYPE_W-1:0] BR_BEQ  = 6'b000001;
  localparam logic [BR_TYPE_W-1:0] BR_BNE  = 6'b000010;
  localparam logic [BR_TYPE_W-1:0] BR_BLT  = 6'b000100;
  localparam logic [BR_TYPE_W-1:0] BR_BGE  = 6'b001000;
  localparam logic [BR_TYPE_W-1:0] BR_BLTU = 6'b010000;
  localparam logic [BR_TYPE_W-1:0] BR_BGEU = 6'b100000;

  localparam logic zero = 1'b0;

  localparam int unsigned PERF_W = 32;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } br_state_e;

  // Counter that sticks at all-ones instead of wrapping.
  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] value);
    return (value == '1) ? value : value + PERF_W'(1);
  endfunction

endpackage

// File: rtl/branch_resolver_branch_cond_unit.sv
// branch_cond_unit
// Purely combinational B-type condition evaluation.
// Ports:
//   br_type   in  6     one-hot branch decode {bgeu, bltu, bge, blt, bne, beq}
//   rs1_data  in  XLEN  first forwarded operand
//   rs2_data  in  XLEN  second forwarded operand
//   taken     out 1     actual branch direction (0 when no decode bit is set)
`timescale 1ns/1ps

module branch_cond_unit
  import branch_resolver_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [BR_TYPE_W-1:0] br_type,
  input  logic [XLEN-1:0]      rs1_data,
  input  logic [XLEN-1:0]      rs2_data,
  output logic                 taken
);

  logic eq;
  logic lt_signed;
  logic lt_unsigned;

  assign eq          = (rs1_data == rs2_data);
  assign lt_signed   = ($signed(rs1_data) < $signed(rs2_data));
  assign lt_unsigned = (rs1_data < rs2_data);

  always_comb begin
    taken = zero;
    case (br_type)
      BR_BEQ:  taken = eq;
      BR_BNE:  taken = !eq;
      BR_BLT:  taken = lt_signed;
      BR_BGE:  taken = !lt_signed;
      BR_BLTU: taken = lt_unsigned;
      BR_BGEU: taken = !lt_unsigned;
      default: taken = zero;
    endcase
  end

endmodule

// File: rtl/branch_resolver.sv
// branch_resolver
// EX-stage branch resolution: evaluates B-type conditions and jalr targets,
// compares them against the prediction carried from fetch, drives predictor
// training, and on a mispredict squashes the younger pipeline and redirects
// fetch. Mispredict info is registered so PL_flush and *_branch_failed are
// high in the same cycles for the predictor rollback.
//
// Optional build macro: BRANCH_RESOLVER_PERF_EN adds three saturating 32-bit
// event counters (perf_branches, perf_mispredicts, perf_jalr_mispredicts).
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   PL_stall                       freezes all state, gates training outputs
//   ex_valid                       EX slot holds a live instruction
//   beq_ex..bgeu_ex, jalr_ex       one-hot decode of the EX instruction
//   rs1_data, rs2_data             forwarded operands
//   pc_ex, imme_ex                 branch PC and immediate
//   prediction_result_ex           direction predicted at fetch
//   jalr_pc_prediction_ex          target predicted at fetch (RAS)
//   B_type, beq..bgeu              training enables (live, unstalled B-type)
//   corrected_result               actual direction of the trained branch
//   *_branch_failed, pc_branch_failed,
//   B_type_prediction_result_branch_failed   registered mispredict info
//   PL_flush                       squash younger pipeline stages
//   redirect_pc                    correct fetch PC, valid while PL_flush
//
// state | meaning
// ------+-----------------------------------------------------------------
// RUN   | normal operation; mispredicts in EX are detected and captured
// FLUSH | PL_flush asserted; EX is wrong-path, down-counter cnt times out
`timescale 1ns/1ps

module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            PL_stall,
  input  logic            ex_valid,
  input  logic            beq_ex,
  input  logic            bne_ex,
  input  logic            blt_ex,
  input  logic            bge_ex,
  input  logic            bltu_ex,
  input  logic            bgeu_ex,
  input  logic            jalr_ex,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] pc_ex,
  input  logic [XLEN-1:0] imme_ex,
  input  logic            prediction_result_ex,
  input  logic [XLEN-1:0] jalr_pc_prediction_ex,
  output logic            B_type,
  output logic            beq,
  output logic            bne,
  output logic            blt,
  output logic            bge,
  output logic            bltu,
  output logic            bgeu,
  output logic            corrected_result,
  output logic            B_type_branch_failed,
  output logic            beq_branch_failed,
  output logic            bne_branch_failed,
  output logic            blt_branch_failed,
  output logic            bge_branch_failed,
  output logic            bltu_branch_failed,
  output logic            bgeu_branch_failed,
  output logic [XLEN-1:0] pc_branch_failed,
  output logic            B_type_prediction_result_branch_failed,
  output logic            PL_flush,
`ifdef BRANCH_RESOLVER_PERF_EN
  output logic [PERF_W-1:0] perf_branches,
  output logic [PERF_W-1:0] perf_mispredicts,
  output logic [PERF_W-1:0] perf_jalr_mispredicts,
`endif
  output logic [XLEN-1:0] redirect_pc
);

  localparam logic [1:0] CNT_LOAD = 2'(FLUSH_CYCLES - 1);

  br_state_e state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       capture;
  logic       release_info;

  logic [BR_TYPE_W-1:0] br_dec;
  logic                 squash;
  logic                 live;
  logic                 b_live;
  logic                 train_en;
  logic                 taken;
  logic                 b_mis;
  logic                 jalr_mis;
  logic [XLEN-1:0]      jalr_sum;
  logic [XLEN-1:0]      jalr_target;
  logic [XLEN-1:0]      correct_pc;

  logic [BR_TYPE_W-1:0] type_failed_q;

  // ---------------------------------------------------------------------------
  // EX-stage evaluation
  // ---------------------------------------------------------------------------
  assign br_dec = {bgeu_ex, bltu_ex, bge_ex, blt_ex, bne_ex, beq_ex};

  // Anything sitting in EX while flushing is wrong-path.
  assign squash   = (state_q == FLUSH);
  assign live     = ex_valid && !squash;
  assign b_live   = live && (|br_dec);
  assign train_en = !PL_stall;

  branch_cond_unit #(
    .XLEN (XLEN)
  ) u_cond (
    .br_type  (br_dec),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .taken    (taken)
  );

  assign b_mis = b_live && (taken != prediction_result_ex);

  assign jalr_sum    = rs1_data + imme_ex;
  assign jalr_target = {jalr_sum[XLEN-1:1], 1'b0};
  assign jalr_mis    = live && jalr_ex && (jalr_target != jalr_pc_prediction_ex);

  always_comb begin
    correct_pc = pc_ex + XLEN'(4);
    if (jalr_mis) begin
      correct_pc = jalr_target;
    end else if (taken) begin
      correct_pc = pc_ex + imme_ex;
    end
  end

  // Training outputs are suppressed during a stall so a held instruction
  // trains the predictor only once, on the cycle it actually advances.
  assign B_type           = b_live && train_en;
  assign beq              = beq_ex  && live && train_en;
  assign bne              = bne_ex  && live && train_en;
  assign blt              = blt_ex  && live && train_en;
  assign bge              = bge_ex  && live && train_en;
  assign bltu             = bltu_ex && live && train_en;
  assign bgeu             = bgeu_ex && live && train_en;
  assign corrected_result = taken && B_type;

  // ---------------------------------------------------------------------------
  // Resolver FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    capture      = 1'b0;
    release_info = 1'b0;
    case (state_q)
      RUN: begin
        if ((b_mis || jalr_mis) && !PL_stall) begin
          state_d = FLUSH;
          cnt_d   = CNT_LOAD;
          capture = 1'b1;
        end
      end
      FLUSH: begin
        if (!PL_stall) begin
          if (cnt_q == 2'd0) begin
            state_d      = RUN;
            release_info = 1'b1;
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  assign PL_flush = (state_q == FLUSH);

  // ---------------------------------------------------------------------------
  // Failed-branch info and redirect target, live exactly while in FLUSH
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || release_info) begin
      B_type_branch_failed                   <= zero;
      type_failed_q                          <= '0;
      pc_branch_failed                       <= '0;
      B_type_prediction_result_branch_failed <= zero;
      redirect_pc                            <= '0;
    end else if (capture) begin
      // A jalr mispredict has no B-type decode bit set, so all B-type
      // failure flags load 0 for it.
      B_type_branch_failed                   <= b_mis;
      type_failed_q                          <= br_dec & {BR_TYPE_W{b_mis}};
      pc_branch_failed                       <= pc_ex;
      B_type_prediction_result_branch_failed <= prediction_result_ex && b_mis;
      redirect_pc                            <= correct_pc;
    end
  end

  assign beq_branch_failed  = type_failed_q[0];
  assign bne_branch_failed  = type_failed_q[1];
  assign blt_branch_failed  = type_failed_q[2];
  assign bge_branch_failed  = type_failed_q[3];
  assign bltu_branch_failed = type_failed_q[4];
  assign bgeu_branch_failed = type_failed_q[5];

  // ---------------------------------------------------------------------------
  // Optional event counters
  // ---------------------------------------------------------------------------
`ifdef BRANCH_RESOLVER_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_branches         <= '0;
      perf_mispredicts      <= '0;
      perf_jalr_mispredicts <= '0;
    end else if (!PL_stall) begin
      if (b_live) begin
        perf_branches <= sat_inc(perf_branches);
      end
      if (b_mis) begin
        perf_mispredicts <= sat_inc(perf_mispredicts);
      end
      if (jalr_mis) begin
        perf_jalr_mispredicts <= sat_inc(perf_jalr_mispredicts);
      end
    end
  end
`else
  // Counters are not built; the resolver behaves identically without them.
`endif

  // Decode bits are one-hot by construction upstream; more than one set
  // makes the condition result meaningless.
  decode_onehot_a : assert property (
    @(posedge clk) disable iff (rst)
    ex_valid |-> $onehot0({jalr_ex, br_dec})
  );

endmodule
